// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-read/multi-write register file.
// Holds the default geometry and the address-width helper used by the top.
package regfile_pkg;

    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefDepth = 32;
    localparam int unsigned DefNr    = 2;
    localparam int unsigned DefNw    = 4;

    // Address bits needed to index `depth` entries.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_entry.sv
// One register-file entry: data and busy flip-flops, NW-way write select and
// busy-bit priority.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   wr_*_i        all write ports (enable, address, data)
//   rsv_en_i/addr reserve request (sets busy)
//   flush_i       clears busy
//   data_nxt_o    entry value after this cycle's writes (feeds read bypass)
//   busy_nxt_o    busy bit after this cycle's updates
//   multi_hit_o   two or more enabled write ports target this entry
module regfile_entry
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned NW        = DefNw,
    parameter int unsigned AW        = 5,
    parameter int unsigned IDX       = 0,
    parameter bit          HARD_ZERO = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NW-1:0]             wr_en_i,
    input  logic [NW-1:0][AW-1:0]     wr_addr_i,
    input  logic [NW-1:0][WIDTH-1:0]  wr_data_i,
    input  logic                      rsv_en_i,
    input  logic [AW-1:0]             rsv_addr_i,
    input  logic                      flush_i,
    output logic [WIDTH-1:0]          data_nxt_o,
    output logic                      busy_nxt_o,
    output logic                      multi_hit_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             busy_q, busy_d;
    logic             any_wr;
    logic             multi;

    always_comb begin
        data_d = data_q;
        any_wr = 1'b0;
        multi  = 1'b0;
        // Ascending scan: the highest-index matching port is assigned last and wins.
        for (int p = 0; p < NW; p++) begin
            if (wr_en_i[p] && (wr_addr_i[p] == AW'(IDX))) begin
                if (any_wr) begin
                    multi = 1'b1;
                end
                data_d = wr_data_i[p];
                any_wr = 1'b1;
            end
        end

        if (flush_i) begin
            busy_d = 1'b0;
        end else if (rsv_en_i && (rsv_addr_i == AW'(IDX))) begin
            busy_d = 1'b1;
        end else if (any_wr) begin
            busy_d = 1'b0;
        end else begin
            busy_d = busy_q;
        end

        if (HARD_ZERO) begin
            data_d = '0;
            busy_d = 1'b0;
            multi  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            busy_q <= 1'b0;
        end else begin
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    assign data_nxt_o  = data_d;
    assign busy_nxt_o  = busy_d;
    assign multi_hit_o = multi;

endmodule

// File: rtl/regfile_mrmw.sv
// Multi-read, multi-write register file with per-entry busy (scoreboard) bits.
// Reads are registered with write-to-read bypass: data/ready reflect the entry
// state after the same cycle's writes, reserves and flush.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   wr_en/addr/data  NW write ports; highest index wins on address conflict
//   rsv_en/addr      mark an entry busy
//   flush_i          clear all busy bits
//   rd_en/addr       NR read requests
//   rd_data_o        registered read data (holds when not requested)
//   rd_valid_o       request issued last cycle
//   rd_ready_o       read entry was not busy (holds when not requested)
//   wr_collision_o   write-address conflict seen last cycle
module regfile_mrmw
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned DEPTH    = DefDepth,
    parameter int unsigned NR       = DefNr,
    parameter int unsigned NW       = DefNw,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned AW      = addr_width(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NW-1:0]             wr_en_i,
    input  logic [NW-1:0][AW-1:0]     wr_addr_i,
    input  logic [NW-1:0][WIDTH-1:0]  wr_data_i,
    input  logic                      rsv_en_i,
    input  logic [AW-1:0]             rsv_addr_i,
    input  logic                      flush_i,
    input  logic [NR-1:0]             rd_en_i,
    input  logic [NR-1:0][AW-1:0]     rd_addr_i,
    output logic [NR-1:0][WIDTH-1:0]  rd_data_o,
    output logic [NR-1:0]             rd_valid_o,
    output logic [NR-1:0]             rd_ready_o,
    output logic                      wr_collision_o
);

    logic [WIDTH-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0] ent_busy;
    logic [DEPTH-1:0] ent_multi;

    logic [NR-1:0][WIDTH-1:0] rd_data_q, rd_data_d;
    logic [NR-1:0]            rd_valid_q, rd_valid_d;
    logic [NR-1:0]            rd_ready_q, rd_ready_d;
    logic                     coll_q, coll_d;

    // Only in-range addresses have an entry, so out-of-range writes and
    // reserves match nothing and are dropped.
    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        regfile_entry #(
            .WIDTH     (WIDTH),
            .NW        (NW),
            .AW        (AW),
            .IDX       (e),
            .HARD_ZERO (ZERO_REG && (e == 0))
        ) u_entry (
            .clk         (clk),
            .rst         (rst),
            .wr_en_i     (wr_en_i),
            .wr_addr_i   (wr_addr_i),
            .wr_data_i   (wr_data_i),
            .rsv_en_i    (rsv_en_i),
            .rsv_addr_i  (rsv_addr_i),
            .flush_i     (flush_i),
            .data_nxt_o  (ent_data[e]),
            .busy_nxt_o  (ent_busy[e]),
            .multi_hit_o (ent_multi[e])
        );
    end

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_ready_d = rd_ready_q;
        rd_valid_d = rd_en_i;
        coll_d     = |ent_multi;
        for (int k = 0; k < NR; k++) begin
            if (rd_en_i[k]) begin
                // Default covers addresses with no backing entry.
                rd_data_d[k]  = '0;
                rd_ready_d[k] = 1'b0;
                for (int e = 0; e < DEPTH; e++) begin
                    if (rd_addr_i[k] == AW'(e)) begin
                        rd_data_d[k]  = ent_data[e];
                        rd_ready_d[k] = ~ent_busy[e];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= '0;
            rd_ready_q <= '0;
            coll_q     <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_ready_q <= rd_ready_d;
            coll_q     <= coll_d;
        end
    end

    assign rd_data_o      = rd_data_q;
    assign rd_valid_o     = rd_valid_q;
    assign rd_ready_o     = rd_ready_q;
    assign wr_collision_o = coll_q;

endmodule

// File: tb/tb_regfile_mrmw.sv
// Bench for regfile_mrmw: default instance checked every cycle against an
// array-based reference model (directed cases then random traffic), plus a
// small NR=4/NW=1/DEPTH=24 instance for out-of-range reads.
module tb_regfile_mrmw;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: defaults (WIDTH 32, DEPTH 32, NR 2, NW 4, ZERO_REG 1).
    logic [3:0]        wr_en;
    logic [3:0][4:0]   wr_addr;
    logic [3:0][31:0]  wr_data;
    logic              rsv_en;
    logic [4:0]        rsv_addr;
    logic              flush;
    logic [1:0]        rd_en;
    logic [1:0][4:0]   rd_addr;
    logic [1:0][31:0]  rd_data;
    logic [1:0]        rd_valid;
    logic [1:0]        rd_ready;
    logic              coll;

    regfile_mrmw u_dut_a (
        .clk            (clk),
        .rst            (rst),
        .wr_en_i        (wr_en),
        .wr_addr_i      (wr_addr),
        .wr_data_i      (wr_data),
        .rsv_en_i       (rsv_en),
        .rsv_addr_i     (rsv_addr),
        .flush_i        (flush),
        .rd_en_i        (rd_en),
        .rd_addr_i      (rd_addr),
        .rd_data_o      (rd_data),
        .rd_valid_o     (rd_valid),
        .rd_ready_o     (rd_ready),
        .wr_collision_o (coll)
    );

    // Instance B: NR 4, NW 1, DEPTH 24 (AW 5).
    logic [0:0]        b_wr_en;
    logic [0:0][4:0]   b_wr_addr;
    logic [0:0][31:0]  b_wr_data;
    logic              b_rsv_en;
    logic [4:0]        b_rsv_addr;
    logic              b_flush;
    logic [3:0]        b_rd_en;
    logic [3:0][4:0]   b_rd_addr;
    logic [3:0][31:0]  b_rd_data;
    logic [3:0]        b_rd_valid;
    logic [3:0]        b_rd_ready;
    logic              b_coll;

    regfile_mrmw #(
        .NR    (4),
        .NW    (1),
        .DEPTH (24)
    ) u_dut_b (
        .clk            (clk),
        .rst            (rst),
        .wr_en_i        (b_wr_en),
        .wr_addr_i      (b_wr_addr),
        .wr_data_i      (b_wr_data),
        .rsv_en_i       (b_rsv_en),
        .rsv_addr_i     (b_rsv_addr),
        .flush_i        (b_flush),
        .rd_en_i        (b_rd_en),
        .rd_addr_i      (b_rd_addr),
        .rd_data_o      (b_rd_data),
        .rd_valid_o     (b_rd_valid),
        .rd_ready_o     (b_rd_ready),
        .wr_collision_o (b_coll)
    );

    // Reference model state for instance A.
    logic [31:0] m_mem [32];
    bit          m_busy [32];
    logic [31:0] e_data [2];
    logic        e_valid [2];
    logic        e_ready [2];
    logic        e_coll;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle_a();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
        rd_en = '0; rd_addr = '0;
    endtask

    task automatic idle_b();
        b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
        b_rsv_en = 1'b0; b_rsv_addr = '0; b_flush = 1'b0;
        b_rd_en = '0; b_rd_addr = '0;
    endtask

    // Apply the currently driven inputs of A to the model.
    task automatic model_a();
        int cnt [32];
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i] = '0;
                m_busy[i] = 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                e_data[k] = '0; e_valid[k] = 1'b0; e_ready[k] = 1'b0;
            end
            e_coll = 1'b0;
            return;
        end
        for (int i = 0; i < 32; i++) cnt[i] = 0;
        for (int p = 0; p < 4; p++) begin
            if (wr_en[p] && wr_addr[p] != 0) begin
                m_mem[wr_addr[p]] = wr_data[p];
                cnt[wr_addr[p]]++;
            end
        end
        e_coll = 1'b0;
        for (int i = 1; i < 32; i++) if (cnt[i] > 1) e_coll = 1'b1;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else begin
            for (int i = 1; i < 32; i++) if (cnt[i] > 0) m_busy[i] = 1'b0;
            if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            e_valid[k] = rd_en[k];
            if (rd_en[k]) begin
                e_data[k]  = m_mem[rd_addr[k]];
                e_ready[k] = !m_busy[rd_addr[k]];
            end
        end
    endtask

    task automatic tick(input string tag);
        model_a();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s rd_data[%0d]", tag, k), rd_data[k], e_data[k]);
            check($sformatf("%s rd_valid[%0d]", tag, k), 32'(rd_valid[k]), 32'(e_valid[k]));
            check($sformatf("%s rd_ready[%0d]", tag, k), 32'(rd_ready[k]), 32'(e_ready[k]));
        end
        check($sformatf("%s wr_collision", tag), 32'(coll), 32'(e_coll));
        idle_a();
        idle_b();
    endtask

    initial begin
        idle_a();
        idle_b();
        rst = 1'b1;
        tick("reset0");
        tick("reset1");
        for (int k = 0; k < 4; k++) begin
            check($sformatf("b reset data[%0d]", k), b_rd_data[k], 32'h0);
            check($sformatf("b reset valid[%0d]", k), 32'(b_rd_valid[k]), 32'h0);
        end
        rst = 1'b0;

        // Read of a freshly reset entry.
        rd_en[0] = 1'b1; rd_addr[0] = 5'd5;
        tick("rd5");
        check("rd5 literal data", rd_data[0], 32'h0);
        check("rd5 literal ready", 32'(rd_ready[0]), 32'h1);

        // Two ports write one address; highest index wins, collision for one cycle.
        wr_en = 4'b1001;
        wr_addr[0] = 5'd3; wr_data[0] = 32'hA;
        wr_addr[3] = 5'd3; wr_data[3] = 32'hB;
        rd_en[1] = 1'b1; rd_addr[1] = 5'd3;
        tick("coll");
        check("coll literal data", rd_data[1], 32'hB);
        check("coll literal flag", 32'(coll), 32'h1);
        tick("coll_after");
        check("coll literal drop", 32'(coll), 32'h0);

        // Reserve then satisfy with a write.
        rsv_en = 1'b1; rsv_addr = 5'd7;
        tick("rsv7");
        rd_en[0] = 1'b1; rd_addr[0] = 5'd7;
        tick("rd7_busy");
        check("rd7 literal not ready", 32'(rd_ready[0]), 32'h0);
        wr_en[2] = 1'b1; wr_addr[2] = 5'd7; wr_data[2] = 32'h55;
        rd_en[0] = 1'b1; rd_addr[0] = 5'd7;
        tick("wr7_bypass");
        check("wr7 literal data", rd_data[0], 32'h55);
        check("wr7 literal ready", 32'(rd_ready[0]), 32'h1);

        // Reserve beats a same-cycle write; write data still lands.
        rsv_en = 1'b1; rsv_addr = 5'd9;
        wr_en[1] = 1'b1; wr_addr[1] = 5'd9; wr_data[1] = 32'h99;
        tick("rsv_wr9");
        rsv_en = 1'b1; rsv_addr = 5'd12;
        rd_en[0] = 1'b1; rd_addr[0] = 5'd9;
        tick("rd9");
        check("rd9 literal data", rd_data[0], 32'h99);
        check("rd9 literal busy", 32'(rd_ready[0]), 32'h0);
        // Flush wins over a same-cycle reserve; the write still commits.
        flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd4;
        wr_en[0] = 1'b1; wr_addr[0] = 5'd20; wr_data[0] = 32'h2020;
        rd_en = 2'b11; rd_addr[0] = 5'd4; rd_addr[1] = 5'd9;
        tick("flush");
        check("flush literal ready4", 32'(rd_ready[0]), 32'h1);
        check("flush literal ready9", 32'(rd_ready[1]), 32'h1);
        rd_en = 2'b11; rd_addr[0] = 5'd12; rd_addr[1] = 5'd20;
        tick("post_flush");
        check("flush literal data20", rd_data[1], 32'h2020);

        // Entry 0 is hardwired zero and never collides.
        wr_en = 4'b0011; wr_addr[0] = 5'd0; wr_addr[1] = 5'd0;
        wr_data[0] = 32'hFFFF_FFFF; wr_data[1] = 32'hFFFF_FFFF;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        rd_en = 2'b11; rd_addr[0] = 5'd0; rd_addr[1] = 5'd0;
        tick("zero_reg");
        check("zero literal data", rd_data[0], 32'h0);
        check("zero literal ready", 32'(rd_ready[1]), 32'h1);
        check("zero literal coll", 32'(coll), 32'h0);

        // Reset during an active read.
        rd_en = 2'b11; rd_addr[0] = 5'd7; rd_addr[1] = 5'd9;
        rst = 1'b1;
        tick("rst_mid");
        rst = 1'b0;
        rd_en = 2'b11; rd_addr[0] = 5'd7; rd_addr[1] = 5'd9;
        tick("after_rst");

        // Instance B: out-of-range reads and writes with DEPTH 24.
        b_wr_en = 1'b1; b_wr_addr[0] = 5'd5; b_wr_data[0] = 32'h1234;
        b_rd_en = 4'b1111;
        b_rd_addr[0] = 5'd30; b_rd_addr[1] = 5'd5; b_rd_addr[2] = 5'd24; b_rd_addr[3] = 5'd0;
        tick("b_step1");
        check("b addr30 data", b_rd_data[0], 32'h0);
        check("b addr30 ready", 32'(b_rd_ready[0]), 32'h0);
        check("b addr5 data", b_rd_data[1], 32'h1234);
        check("b addr5 ready", 32'(b_rd_ready[1]), 32'h1);
        check("b addr24 ready", 32'(b_rd_ready[2]), 32'h0);
        check("b addr0 ready", 32'(b_rd_ready[3]), 32'h1);
        check("b valid", 32'(b_rd_valid), 32'hF);
        b_wr_en = 1'b1; b_wr_addr[0] = 5'd28; b_wr_data[0] = 32'hFFFF;
        b_rsv_en = 1'b1; b_rsv_addr = 5'd28;
        b_rd_en = 4'b0001; b_rd_addr[0] = 5'd28;
        tick("b_step2");
        check("b addr28 data", b_rd_data[0], 32'h0);
        check("b addr28 ready", 32'(b_rd_ready[0]), 32'h0);
        check("b hold data1", b_rd_data[1], 32'h1234);
        check("b valid2", 32'(b_rd_valid), 32'h1);
        check("b coll", 32'(b_coll), 32'h0);

        // Random traffic on instance A.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            wr_en = 4'($urandom);
            for (int p = 0; p < 4; p++) begin
                wr_addr[p] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
                wr_data[p] = $urandom;
            end
            rsv_en = ($urandom_range(0, 2) == 0);
            rsv_addr = 5'($urandom_range(0, 9));
            flush = ($urandom_range(0, 15) == 0);
            rd_en = 2'($urandom);
            for (int k = 0; k < 2; k++) rd_addr[k] = 5'($urandom_range(0, 9));
            tick($sformatf("rand%0d", n));
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
